// File: rtl/rv32i_gcd_host.sv
// Host sequencer for the RV32I core's GCD pins: it latches an operand pair, holds the core in reset, releases it, and returns the result.
// Build with GCD_HOST_TIMEOUT_EN defined to abort RUN after TIMEOUT_CYCLES cycles with resp_err set.
module rv32i_gcd_host #(
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        core_rst_n,
  output logic        calc_start,
  output logic [31:0] gcd_a,
  output logic [31:0] gcd_b,
  input  logic [31:0] gcd_result
);

  typedef enum logic [1:0] {IDLE, CRST, RUN, DONE} state_t;

  localparam int unsigned RST_CNT_W = $clog2(RST_CYCLES + 1);

  state_t                 state_q, state_d;
  logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_data_q, resp_data_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   calc_start_q, calc_start_d;
  logic [31:0]            gcd_a_q, gcd_a_d;
  logic [31:0]            gcd_b_q, gcd_b_d;

  logic req_fire;
  logic zero_operand;
  logic result_seen;

  assign req_fire     = (state_q == IDLE) && req_valid && req_ready_q;
  assign zero_operand = (req_a == 32'd0) || (req_b == 32'd0);
  assign result_seen  = (state_q == RUN) && (gcd_result != 32'd0);

`ifdef GCD_HOST_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] run_cnt_q, run_cnt_d;
  logic            resp_err_q, resp_err_d;
  logic            timeout_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      core_rst_n_q <= 1'b0;
      calc_start_q <= 1'b0;
      gcd_a_q      <= 32'd0;
      gcd_b_q      <= 32'd0;
`ifdef GCD_HOST_TIMEOUT_EN
      run_cnt_q    <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      core_rst_n_q <= core_rst_n_d;
      calc_start_q <= calc_start_d;
      gcd_a_q      <= gcd_a_d;
      gcd_b_q      <= gcd_b_d;
`ifdef GCD_HOST_TIMEOUT_EN
      run_cnt_q    <= run_cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  // CRST is entered on the accept edge and left once the counter has reached RST_CYCLES.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
`ifdef GCD_HOST_TIMEOUT_EN
    run_cnt_d   = run_cnt_q;
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (zero_operand) begin
            state_d = DONE;
          end else begin
            state_d   = CRST;
            rst_cnt_d = '0;
          end
        end
      end
      CRST: begin
        if (rst_cnt_q == RST_CNT_W'(RST_CYCLES)) begin
          state_d = RUN;
`ifdef GCD_HOST_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (result_seen) begin
          state_d = DONE;
        end else begin
`ifdef GCD_HOST_TIMEOUT_EN
          run_cnt_d = run_cnt_q + 1'b1;
          if (run_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = DONE;
            timeout_hit = 1'b1;
          end
`endif
        end
      end
      DONE: begin
        if (resp_valid_q && resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    core_rst_n_d = (state_d == RUN);
    calc_start_d = (state_d == RUN);
    gcd_a_d      = gcd_a_q;
    gcd_b_d      = gcd_b_q;
    resp_data_d  = resp_data_q;
`ifdef GCD_HOST_TIMEOUT_EN
    resp_err_d   = resp_err_q;
`endif
    if (req_fire) begin
      gcd_a_d     = req_a;
      gcd_b_d     = req_b;
      resp_data_d = zero_operand ? (req_a | req_b) : 32'd0;
`ifdef GCD_HOST_TIMEOUT_EN
      resp_err_d  = 1'b0;
`endif
    end
    if (result_seen) begin
      resp_data_d = gcd_result;
`ifdef GCD_HOST_TIMEOUT_EN
      resp_err_d  = 1'b0;
`endif
    end
`ifdef GCD_HOST_TIMEOUT_EN
    if (timeout_hit) begin
      resp_data_d = 32'd0;
      resp_err_d  = 1'b1;
    end
`endif
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign core_rst_n = core_rst_n_q;
  assign calc_start = calc_start_q;
  assign gcd_a      = gcd_a_q;
  assign gcd_b      = gcd_b_q;

`ifdef GCD_HOST_TIMEOUT_EN
  assign resp_err = resp_err_q;
`else
  // Without the timeout there is no abort path; TIMEOUT_CYCLES has no effect here.
  assign resp_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_rv32i_gcd_host.sv
// Directed plus randomized bench for rv32i_gcd_host with a behavioural core model and a Euclid reference.
module tb_rv32i_gcd_host;

  localparam int RS = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        core_rst_n;
  logic        calc_start;
  logic [31:0] gcd_a;
  logic [31:0] gcd_b;
  logic [31:0] gcd_result = 32'd0;

  int checks   = 0;
  int failures = 0;
  int core_latency = 0;
  int core_cnt     = 0;

  always #5 clk = ~clk;

  rv32i_gcd_host #(
    .RST_CYCLES    (RS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .core_rst_n(core_rst_n),
    .calc_start(calc_start),
    .gcd_a     (gcd_a),
    .gcd_b     (gcd_b),
    .gcd_result(gcd_result)
  );

  function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: cleared while in reset, writes the GCD core_latency cycles after release (0 = never).
  always @(posedge clk) begin
    if (!core_rst_n) begin
      gcd_result <= 32'd0;
      core_cnt   <= 0;
    end else if (calc_start) begin
      core_cnt <= core_cnt + 1;
      if (core_latency != 0 && core_cnt + 1 == core_latency)
        gcd_result <= gcd_ref(gcd_a, gcd_b);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"},  {31'd0, req_ready},  32'd0);
    checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
    checkOutput({tag, "_resp_data"},  resp_data,           32'd0);
    checkOutput({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    checkOutput({tag, "_calc_start"}, {31'd0, calc_start}, 32'd0);
    checkOutput({tag, "_gcd_a"},      gcd_a,               32'd0);
    checkOutput({tag, "_gcd_b"},      gcd_b,               32'd0);
  endtask

  // Entered at a negedge; leaves at the first negedge after the accept edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic runJob(input logic [31:0] a, input logic [31:0] b, input int lat, input int hold);
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_n;
    int          exp_rel;
    int          n      = 0;
    int          rel_n  = -1;
    bit          stable = 1;
    bit          ready_low = 1;
    bit          held_ok   = 1;

    if (a == 0 || b == 0) begin
      exp_data = a | b;
      exp_err  = 1'b0;
      exp_n    = 0;
      exp_rel  = -1;
    end else begin
      exp_rel  = RS + 1;
      exp_data = gcd_ref(a, b);
      exp_err  = 1'b0;
      exp_n    = RS + lat + 2;
`ifdef GCD_HOST_TIMEOUT_EN
      if (lat == 0 || lat + 1 > TO) begin
        exp_data = 32'd0;
        exp_err  = 1'b1;
        exp_n    = RS + 1 + TO;
      end
`endif
    end

    core_latency = lat;
    applyStimulus(a, b);
    while (resp_valid !== 1'b1 && n < 400) begin
      if (core_rst_n === 1'b1 && rel_n < 0) rel_n = n;
      if (gcd_a !== a || gcd_b !== b) stable = 0;
      if (req_ready !== 1'b0) ready_low = 0;
      @(negedge clk);
      n++;
    end
    checkOutput("resp_latency",   n,                   exp_n);
    checkOutput("core_release",   rel_n,               exp_rel);
    checkOutput("operand_stable", {31'd0, stable},     32'd1);
    checkOutput("busy_not_ready", {31'd0, ready_low},  32'd1);
    checkOutput("resp_data",      resp_data,           exp_data);
    checkOutput("resp_err",       {31'd0, resp_err},   {31'd0, exp_err});
    checkOutput("core_held_done", {31'd0, core_rst_n}, 32'd0);

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a     = $urandom;
      req_b     = $urandom;
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== exp_data || req_ready !== 1'b0 || gcd_a !== a)
        held_ok = 0;
    end
    checkOutput("resp_hold", {31'd0, held_ok}, 32'd1);

    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_released", {31'd0, resp_valid}, 32'd0);
    checkOutput("ready_after",   {31'd0, req_ready},  32'd1);
  endtask

  initial begin
    bit no_resp = 1;
    logic [31:0] g, ra, rb;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'd0, req_ready}, 32'd1);

    $display("[TB] directed jobs");
    runJob(32'd48, 32'd18, 20, 0);
    runJob(32'd0,  32'd7,  5,  0);
    runJob(32'd0,  32'd0,  5,  0);
    runJob(32'd35, 32'd14, 8,  5);

`ifdef GCD_HOST_TIMEOUT_EN
    $display("[TB] timeout jobs");
    runJob(32'd100, 32'd75, 0,  0);
    runJob(32'd100, 32'd75, 15, 0);
    runJob(32'd100, 32'd75, 16, 0);
`endif

    $display("[TB] reset during RUN");
    core_latency = 20;
    applyStimulus(32'd48, 32'd18);
    repeat (RS + 4) @(negedge clk);
    checkOutput("mid_run_active", {31'd0, core_rst_n}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetOutputs("mid_reset");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) no_resp = 0;
    end
    checkOutput("no_resp_after_reset", {31'd0, no_resp}, 32'd1);
    runJob(32'd9, 32'd6, 5, 0);

    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      g  = $urandom_range(1, 50);
      ra = g * $urandom_range(0, 40);
      rb = g * $urandom_range(1, 40);
      runJob(ra, rb, $urandom_range(1, 10), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
